// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg
// Shared definitions for the multiplexed BCD 7-segment display driver:
// active-low segment patterns ({g,f,e,d,c,b,a}, 0 = segment lit) and the
// digit-scan state encoding.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  // Non-BCD codes 10..15 show a lone middle bar.
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  // All segments dark.
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // DIG0 drives the ones digit, DIG1 the tens digit.
  typedef enum logic [0:0] {
    DIG0 = 1'b0,
    DIG1 = 1'b1
  } scan_state_e;

endpackage

// File: rtl/bcd_seg_scan_if.sv
// bcd_seg_scan_if
// Bundles the display driver's data path: BCD digits, terminal-count pulse
// and enable going in; active-low segments, decimal point and anodes out.
//   en   : display enable
//   q0   : ones digit (BCD)
//   q1   : tens digit (BCD)
//   tc   : terminal-count pulse
//   seg  : segments {g,f,e,d,c,b,a}, active-low
//   dp   : decimal point, active-low
//   an   : digit anodes, active-low; an[0] ones, an[1] tens
// master = the side producing digits (counter / bench), slave = the driver.
interface bcd_seg_scan_if;

  logic       en;
  logic [3:0] q0;
  logic [3:0] q1;
  logic       tc;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;

  modport master (
    output en, q0, q1, tc,
    input  seg, dp, an
  );

  modport slave (
    input  en, q0, q1, tc,
    output seg, dp, an
  );

endinterface

// File: rtl/bcd_to_seg.sv
// bcd_to_seg
// Purely combinational BCD to active-low 7-segment decoder.
//   bcd : 4-bit input code
//   seg : {g,f,e,d,c,b,a}, 0 = lit; codes 10..15 decode to a dash
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Digit lookup; anything that is not a decimal digit becomes a dash.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan
// Two-digit multiplexed common-anode display driver. Snapshots the ones/tens
// BCD digits once per refresh frame, alternates the two digit slots every
// SCAN_DIV clocks, blanks a leading tens zero (LZ_BLANK), shows a dash for
// non-BCD codes and lights the ones-digit decimal point for DP_HOLD frames
// after each terminal-count pulse.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : bcd_seg_scan_if.slave (en, q0, q1, tc in; seg, dp, an out)
// All outputs are registered and lag the scan state by one clock.
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DP_HOLD  = 50,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  bcd_seg_scan_if.slave   bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DP_HOLD > 0) ? $clog2(DP_HOLD + 1) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DPC_LOAD = DW'(DP_HOLD);

  logic [PW-1:0] pcnt_r;
  scan_state_e   state_r;
  scan_state_e   state_nxt_s;
  logic [3:0]    s0_r;
  logic [3:0]    s1_r;
  logic [DW-1:0] dpc_r;
  logic          run_r;
  logic          tick_s;
  logic          load_s;
  logic          frame_s;
  logic [3:0]    digit_s;
  logic [6:0]    dec_s;
  logic [6:0]    seg_nxt_s;
  logic          dp_nxt_s;
  logic [1:0]    an_nxt_s;

  assign tick_s  = (pcnt_r == PCNT_MAX);
  // Snapshot point: first cycle of the ones slot.
  assign load_s  = bus.en && (state_r == DIG0) && (pcnt_r == {PW{1'b0}});
  // Frame boundary: the tens slot is ending.
  assign frame_s = bus.en && tick_s && (state_r == DIG1);

  // Slot prescaler; held at zero while the display is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_r <= {PW{1'b0}};
    end else if (!bus.en || tick_s) begin
      pcnt_r <= {PW{1'b0}};
    end else begin
      pcnt_r <= pcnt_r + PW'(1);
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= DIG0;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Scan FSM next-state: alternate slots on each tick, restart at ones when disabled.
  always_comb begin
    state_nxt_s = state_r;
    if (!bus.en) begin
      state_nxt_s = DIG0;
    end else begin
      case (state_r)
        DIG0:    state_nxt_s = tick_s ? DIG1 : DIG0;
        DIG1:    state_nxt_s = tick_s ? DIG0 : DIG1;
        default: state_nxt_s = DIG0;
      endcase
    end
  end

  // Frame snapshot of both digits so a frame never mixes two samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_r <= 4'd0;
      s1_r <= 4'd0;
    end else if (load_s) begin
      s0_r <= bus.q0;
      s1_r <= bus.q1;
    end else begin
      s0_r <= s0_r;
      s1_r <= s1_r;
    end
  end

  // Decimal-point stretcher: tc reloads (and wins), frames count it down.
  always_ff @(posedge clk) begin
    if (rst) begin
      dpc_r <= {DW{1'b0}};
    end else if (bus.tc) begin
      dpc_r <= DPC_LOAD;
    end else if (frame_s && (dpc_r != {DW{1'b0}})) begin
      dpc_r <= dpc_r - DW'(1);
    end else begin
      dpc_r <= dpc_r;
    end
  end

  // Scan-running flag; outputs stay dark for the first cycle after enable so
  // the first lit slot already shows the fresh snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_r <= 1'b0;
    end else begin
      run_r <= bus.en;
    end
  end

  // Digit select for the single decoder. On the snapshot cycle the shadow is
  // being written this very edge, so the incoming q0 is passed through to keep
  // the first ones-slot cycle consistent with the rest of the slot.
  always_comb begin
    digit_s = s0_r;
    if (state_r == DIG1) begin
      digit_s = s1_r;
    end else if (load_s) begin
      digit_s = bus.q0;
    end else begin
      digit_s = s0_r;
    end
  end

  bcd_to_seg u_dec (
    .bcd (digit_s),
    .seg (dec_s)
  );

  // Scan FSM output decode into next values of the output registers.
  always_comb begin
    seg_nxt_s = SEG_OFF;
    dp_nxt_s  = 1'b1;
    an_nxt_s  = 2'b11;
    if (run_r) begin
      case (state_r)
        DIG0: begin
          seg_nxt_s = dec_s;
          an_nxt_s  = 2'b10;
          dp_nxt_s  = (dpc_r == {DW{1'b0}});
        end
        DIG1: begin
          if (LZ_BLANK && (s1_r == 4'd0)) begin
            seg_nxt_s = SEG_OFF;
            an_nxt_s  = 2'b11;
          end else begin
            seg_nxt_s = dec_s;
            an_nxt_s  = 2'b01;
          end
        end
        default: begin
          seg_nxt_s = SEG_OFF;
          an_nxt_s  = 2'b11;
        end
      endcase
    end else begin
      seg_nxt_s = SEG_OFF;
      dp_nxt_s  = 1'b1;
      an_nxt_s  = 2'b11;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.seg <= SEG_OFF;
      bus.dp  <= 1'b1;
      bus.an  <= 2'b11;
    end else begin
      bus.seg <= seg_nxt_s;
      bus.dp  <= dp_nxt_s;
      bus.an  <= an_nxt_s;
    end
  end

endmodule
